// File: rtl/display_pkg.sv
// Shared constants and types for the 7-segment display readback path.
// Segment codes are active-high in a..g order ([6]=g .. [0]=a).
package display_pkg;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  // Active-low, one-cold digit enables; idx0 is the ones digit.
  localparam logic [3:0] DS_IDX0 = 4'b1110;
  localparam logic [3:0] DS_IDX1 = 4'b1101;
  localparam logic [3:0] DS_IDX2 = 4'b1011;
  localparam logic [3:0] DS_IDX3 = 4'b0111;

  typedef struct packed {
    logic [3:0] value;
    logic       blank;
    logic       err;
  } digit_t;

  function automatic logic [13:0] bcd_to_bin(input logic [3:0] d3, input logic [3:0] d2,
                                             input logic [3:0] d1, input logic [3:0] d0);
    return (14'(d3) * 14'd1000) + (14'(d2) * 14'd100) + (14'(d1) * 14'd10) + 14'(d0);
  endfunction

endpackage

// File: rtl/seven_seg_decode.sv
// Combinational 7-segment to BCD decoder; takes active-low segment pins.
// Unknown segment patterns raise err, an all-dark digit raises blank.
module seven_seg_decode
  import display_pkg::*;
(
  input  logic [6:0] seg_n_i,
  output digit_t     digit_o
);

  logic [6:0] seg_s;

  assign seg_s = ~seg_n_i;

  // Map the active-high segment pattern to a digit value.
  always_comb begin
    digit_o = '{value: 4'd0, blank: 1'b0, err: 1'b0};
    case (seg_s)
      SEG_0:     digit_o.value = 4'd0;
      SEG_1:     digit_o.value = 4'd1;
      SEG_2:     digit_o.value = 4'd2;
      SEG_3:     digit_o.value = 4'd3;
      SEG_4:     digit_o.value = 4'd4;
      SEG_5:     digit_o.value = 4'd5;
      SEG_6:     digit_o.value = 4'd6;
      SEG_7:     digit_o.value = 4'd7;
      SEG_8:     digit_o.value = 4'd8;
      SEG_9:     digit_o.value = 4'd9;
      SEG_BLANK: digit_o.blank = 1'b1;
      default:   digit_o.err   = 1'b1;
    endcase
  end

endmodule

// File: rtl/display_reader.sv
// Readback front end for the multiplexed 7-segment bus: debounces each digit
// slot, decodes it and assembles complete 4-digit frames into a binary number.
module display_reader
  import display_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int TIMEOUT       = 2**21
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  digit_select,
  input  logic [6:0]  led_select,
  output logic [13:0] number,
  output logic        frame_valid,
  output logic        decode_error,
  output logic        stalled
);

  localparam int STAB_W = $clog2(STABLE_CYCLES) + 1;
  localparam int TO_W   = $clog2(TIMEOUT) + 1;
  localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(STABLE_CYCLES - 1);
  localparam logic [STAB_W-1:0] STAB_PRE  = STAB_W'(STABLE_CYCLES - 2);
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT - 1);

  logic [3:0]        ds_prev_q, ds_prev_d;
  logic [6:0]        led_prev_q, led_prev_d;
  logic [STAB_W-1:0] stab_q, stab_d;
  logic              taken_q, taken_d;
  logic [TO_W-1:0]   to_q, to_d;
  logic [3:0]        seen_q, seen_d;
  logic [3:0]        blank_q, blank_d;
  logic              err_q, err_d;
  logic [3:0][3:0]   val_q, val_d;
  logic [13:0]       number_q, number_d;
  logic              fv_q, fv_d;
  logic              de_q, de_d;
  logic              stalled_q, stalled_d;

  logic              ds_valid_s;
  logic [1:0]        idx_s;
  logic              ds_changed_s;
  logic              changed_s;
  logic              sample_s;
  logic              complete_s;
  logic              frame_ok_s;
  logic              timeout_hit_s;
  digit_t            dec_s;

  seven_seg_decode u_decode (
    .seg_n_i (led_select),
    .digit_o (dec_s)
  );

  // Classify the digit-select pattern; anything not one-cold is idle.
  always_comb begin
    ds_valid_s = 1'b1;
    idx_s      = 2'd0;
    case (digit_select)
      DS_IDX0: idx_s = 2'd0;
      DS_IDX1: idx_s = 2'd1;
      DS_IDX2: idx_s = 2'd2;
      DS_IDX3: idx_s = 2'd3;
      default: ds_valid_s = 1'b0;
    endcase
  end

  // Next-state logic for the stability filter, frame assembly and timeout.
  always_comb begin
    ds_prev_d    = digit_select;
    led_prev_d   = led_select;
    ds_changed_s = (digit_select != ds_prev_q);
    changed_s    = ds_changed_s || (led_select != led_prev_q);

    // Sample on the cycle the counter steps onto its last value, once per activation.
    sample_s = ds_valid_s && !changed_s && !taken_q && (stab_q == STAB_PRE);

    if (!ds_valid_s || changed_s) begin
      stab_d = {STAB_W{1'b0}};
    end else if (stab_q != STAB_LAST) begin
      stab_d = stab_q + STAB_W'(1);
    end else begin
      stab_d = stab_q;
    end

    if (!ds_valid_s || ds_changed_s) begin
      taken_d = 1'b0;
    end else if (sample_s) begin
      taken_d = 1'b1;
    end else begin
      taken_d = taken_q;
    end

    if (sample_s) begin
      to_d = {TO_W{1'b0}};
    end else if (to_q != TO_LAST) begin
      to_d = to_q + TO_W'(1);
    end else begin
      to_d = to_q;
    end
    timeout_hit_s = !sample_s && (to_d == TO_LAST);

    if (sample_s) begin
      stalled_d = 1'b0;
    end else if (timeout_hit_s) begin
      stalled_d = 1'b1;
    end else begin
      stalled_d = stalled_q;
    end

    // Blanks may only occupy the leading positions and never the ones digit.
    complete_s = (seen_q == 4'hF);
    frame_ok_s = !err_q && !blank_q[0] &&
                 (!blank_q[1] || blank_q[2]) &&
                 (!blank_q[2] || blank_q[3]);

    fv_d = complete_s && frame_ok_s;
    de_d = complete_s && !frame_ok_s;
    if (complete_s && frame_ok_s) begin
      number_d = bcd_to_bin(blank_q[3] ? 4'd0 : val_q[3], blank_q[2] ? 4'd0 : val_q[2],
                            blank_q[1] ? 4'd0 : val_q[1], val_q[0]);
    end else begin
      number_d = number_q;
    end

    val_d = val_q;
    if (complete_s || timeout_hit_s) begin
      seen_d  = 4'h0;
      blank_d = 4'h0;
      err_d   = 1'b0;
    end else begin
      seen_d  = seen_q;
      blank_d = blank_q;
      err_d   = err_q;
    end

    if (sample_s) begin
      val_d[idx_s]   = dec_s.value;
      blank_d[idx_s] = dec_s.blank;
      seen_d[idx_s]  = 1'b1;
      err_d          = err_d || dec_s.err;
    end else begin
      val_d = val_d;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ds_prev_q  <= 4'hF;
      led_prev_q <= 7'h7F;
      stab_q     <= {STAB_W{1'b0}};
      taken_q    <= 1'b0;
      to_q       <= {TO_W{1'b0}};
      seen_q     <= 4'h0;
      blank_q    <= 4'h0;
      err_q      <= 1'b0;
      val_q      <= '0;
      number_q   <= 14'd0;
      fv_q       <= 1'b0;
      de_q       <= 1'b0;
      stalled_q  <= 1'b0;
    end else begin
      ds_prev_q  <= ds_prev_d;
      led_prev_q <= led_prev_d;
      stab_q     <= stab_d;
      taken_q    <= taken_d;
      to_q       <= to_d;
      seen_q     <= seen_d;
      blank_q    <= blank_d;
      err_q      <= err_d;
      val_q      <= val_d;
      number_q   <= number_d;
      fv_q       <= fv_d;
      de_q       <= de_d;
      stalled_q  <= stalled_d;
    end
  end

  assign number       = number_q;
  assign frame_valid  = fv_q;
  assign decode_error = de_q;
  assign stalled      = stalled_q;

endmodule

// File: tb/tb_display_reader.sv
// Scoreboard bench for display_reader: stimulus pushes expected frame events,
// a negedge monitor pops and checks kind, number and arrival cycle.
module tb_display_reader;

  localparam int HOLD = 16;
  localparam int GAP  = 4;
  localparam logic [6:0] LED_BLANK = 7'h7F;
  localparam logic [6:0] LED_ONLYA = 7'b1111110;

  typedef struct {
    bit          is_err;
    logic [13:0] num;
    int          due;
  } exp_t;

  logic        clk;
  logic        reset;
  logic [3:0]  digit_select;
  logic [6:0]  led_select;
  logic [13:0] number;
  logic        frame_valid;
  logic        decode_error;
  logic        stalled;

  int   total;
  int   bad;
  int   cyc;
  exp_t q[$];

  display_reader #(.STABLE_CYCLES(4), .TIMEOUT(64)) dut (
    .clk          (clk),
    .reset        (reset),
    .digit_select (digit_select),
    .led_select   (led_select),
    .number       (number),
    .frame_valid  (frame_valid),
    .decode_error (decode_error),
    .stalled      (stalled)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [6:0] led_of(input int d);
    logic [6:0] tab [10];
    tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
    return ~tab[d];
  endfunction

  function automatic logic [3:0] pat(input int idx);
    case (idx)
      0:       return 4'b1110;
      1:       return 4'b1101;
      2:       return 4'b1011;
      default: return 4'b0111;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every frame event must match the head of the scoreboard.
  always @(negedge clk) begin
    if (frame_valid && decode_error) begin
      total++;
      bad++;
      $display("FAIL both_pulses: frame_valid and decode_error high together at cycle %0d", cyc);
    end
    if (frame_valid || decode_error) begin
      exp_t e;
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_event: fv=%0b de=%0b number=%0d at cycle %0d, expected none",
                 frame_valid, decode_error, number, cyc);
      end else begin
        e = q.pop_front();
        if (decode_error !== e.is_err || number !== e.num || cyc != e.due) begin
          bad++;
          $display("FAIL frame_event: got err=%0b number=%0d cycle=%0d, expected err=%0b number=%0d cycle=%0d",
                   decode_error, number, cyc, e.is_err, e.num, e.due);
        end
      end
    end
  end

  // Drive one digit slot, optionally preceded by a short glitch value.
  task automatic drive_digit(input int idx, input logic [6:0] led, input logic [6:0] pre_led,
                             input int pre_n, input bit last, input bit is_err,
                             input logic [13:0] num);
    exp_t e;
    if (pre_n > 0) begin
      digit_select = pat(idx);
      led_select   = pre_led;
      repeat (pre_n) @(negedge clk);
    end
    digit_select = pat(idx);
    led_select   = led;
    if (last) begin
      e.is_err = is_err;
      e.num    = num;
      e.due    = cyc + 5;
      q.push_back(e);
    end
    repeat (HOLD) @(negedge clk);
    digit_select = 4'hF;
    repeat (GAP) @(negedge clk);
  endtask

  task automatic send_frame(input logic [6:0] l3, input logic [6:0] l2, input logic [6:0] l1,
                            input logic [6:0] l0, input bit reorder, input bit is_err,
                            input logic [13:0] num);
    logic [6:0] l [4];
    int ord [4];
    l = '{l0, l1, l2, l3};
    if (reorder) ord = '{2, 3, 0, 1};
    else         ord = '{0, 1, 2, 3};
    for (int i = 0; i < 4; i++)
      drive_digit(ord[i], l[ord[i]], 7'h7F, 0, (i == 3), is_err, num);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    cyc   = 0;
    reset = 1'b0;
    digit_select = 4'hF;
    led_select   = 7'h7F;
    repeat (3) @(negedge clk);
    chk("reset_number", 32'(number), 32'd0);
    chk("reset_fv", 32'(frame_valid), 32'd0);
    chk("reset_de", 32'(decode_error), 32'd0);
    chk("reset_stalled", 32'(stalled), 32'd0);
    reset = 1'b1;
    @(negedge clk);

    // 1: basic frames, including the 9999 upper bound
    send_frame(led_of(1), led_of(2), led_of(3), led_of(4), 1'b0, 1'b0, 14'd1234);
    chk("number_1234", 32'(number), 32'd1234);
    send_frame(led_of(9), led_of(9), led_of(9), led_of(9), 1'b0, 1'b0, 14'd9999);

    // 2: leading blanks accepted, blank under a digit rejected
    send_frame(LED_BLANK, LED_BLANK, led_of(4), led_of(2), 1'b0, 1'b0, 14'd42);
    chk("number_42", 32'(number), 32'd42);
    send_frame(led_of(5), LED_BLANK, led_of(1), led_of(0), 1'b0, 1'b1, 14'd42);
    send_frame(led_of(1), led_of(1), led_of(1), LED_BLANK, 1'b0, 1'b1, 14'd42);

    // 3: illegal segment code in idx1
    send_frame(led_of(7), led_of(8), LED_ONLYA, led_of(9), 1'b0, 1'b1, 14'd42);
    chk("number_hold", 32'(number), 32'd42);

    // 4: 8 flashes for two cycles on the thousands digit before settling on 3
    drive_digit(0, led_of(0), 7'h7F, 0, 1'b0, 1'b0, 14'd0);
    drive_digit(1, led_of(1), 7'h7F, 0, 1'b0, 1'b0, 14'd0);
    drive_digit(2, led_of(2), 7'h7F, 0, 1'b0, 1'b0, 14'd0);
    drive_digit(3, led_of(3), led_of(8), 2, 1'b1, 1'b0, 14'd3210);

    // 5: partial frame lost on stall, resume out of order
    drive_digit(0, led_of(9), 7'h7F, 0, 1'b0, 1'b0, 14'd0);
    drive_digit(1, led_of(9), 7'h7F, 0, 1'b0, 1'b0, 14'd0);
    repeat (40) @(negedge clk);
    chk("not_stalled_yet", 32'(stalled), 32'd0);
    repeat (20) @(negedge clk);
    chk("stalled_set", 32'(stalled), 32'd1);
    digit_select = pat(2);
    led_select   = led_of(2);
    repeat (2) @(negedge clk);
    chk("stalled_before_sample", 32'(stalled), 32'd1);
    repeat (HOLD - 2) @(negedge clk);
    chk("stalled_cleared", 32'(stalled), 32'd0);
    digit_select = 4'hF;
    repeat (GAP) @(negedge clk);
    drive_digit(3, led_of(1), 7'h7F, 0, 1'b0, 1'b0, 14'd0);
    drive_digit(0, led_of(4), 7'h7F, 0, 1'b0, 1'b0, 14'd0);
    drive_digit(1, led_of(3), 7'h7F, 0, 1'b1, 1'b0, 14'd1234);

    // 6: reset in the middle of a 9876 frame
    drive_digit(0, led_of(6), 7'h7F, 0, 1'b0, 1'b0, 14'd0);
    drive_digit(1, led_of(7), 7'h7F, 0, 1'b0, 1'b0, 14'd0);
    reset = 1'b0;
    #1;
    chk("rst_mid_number", 32'(number), 32'd0);
    chk("rst_mid_fv", 32'(frame_valid), 32'd0);
    chk("rst_mid_stalled", 32'(stalled), 32'd0);
    repeat (3) @(negedge clk);
    chk("rst_mid_de", 32'(decode_error), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    send_frame(led_of(5), led_of(5), led_of(5), led_of(5), 1'b1, 1'b0, 14'd5555);
    chk("number_5555", 32'(number), 32'd5555);

    repeat (10) @(negedge clk);
    chk("scoreboard_empty", 32'(q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
